// File: rtl/onehot_rr_arbiter.sv
// Packet-level round-robin arbiter: one-hot grant, AND-OR data mux, single
// registered output stage with valid/ready. Ownership spans first..last beat.

module onehot_rr_arbiter_lane #(
  parameter int Width = 8
) (
  input  logic             sel,
  input  logic [Width-1:0] data,
  input  logic             last,
  output logic [Width-1:0] data_g,
  output logic             last_g
);
  assign data_g = data & {Width{sel}};
  assign last_g = last & sel;
endmodule

module onehot_rr_arbiter #(
  parameter int Count = 3,
  parameter int Width = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [Count-1:0]            req_valid_i,
  input  logic [Count-1:0][Width-1:0] req_data_i,
  input  logic [Count-1:0]            req_last_i,
  output logic [Count-1:0]            req_ready_o,
  output logic [Count-1:0]            grant_o,
  output logic                        out_valid_o,
  output logic [Width-1:0]            out_data_o,
  output logic                        out_last_o,
  input  logic                        out_ready_i
);
  localparam int IW = (Count > 1) ? $clog2(Count) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                      state;
  logic [IW-1:0]               ptr, owner, win_idx, scan_idx;
  logic                        win_vld, free, acc;
  logic [Count-1:0]            win_oh, sel, last_g;
  logic [Count-1:0][Width-1:0] data_g;
  logic [Width-1:0]            mux_data;
  logic                        mux_last;

  assign free = !out_valid_o || out_ready_i;

  // Scan farthest-to-nearest from ptr+1 so the nearest valid requester wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int i = Count; i >= 1; i--) begin
      scan_idx = IW'((int'(ptr) + i) % Count);
      if (req_valid_i[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int k = 0; k < Count; k++)
      win_oh[k] = win_vld && (win_idx == IW'(k));
  end

  assign sel = (state == LOCKED) ? grant_o : win_oh;

  always_comb begin
    req_ready_o = '0;
    if (!rst_i) req_ready_o = sel & {Count{free}};
  end

  assign acc = |(req_valid_i & req_ready_o);

  for (genvar g = 0; g < Count; g++) begin : g_lane
    onehot_rr_arbiter_lane #(.Width(Width)) u_lane (
      .sel    (sel[g]),
      .data   (req_data_i[g]),
      .last   (req_last_i[g]),
      .data_g (data_g[g]),
      .last_g (last_g[g])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < Count; k++) mux_data |= data_g[k];
  end
  assign mux_last = |last_g;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= IW'(Count - 1);
      owner       <= '0;
      grant_o     <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else begin
      if (acc) begin
        out_valid_o <= 1'b1;
        out_data_o  <= mux_data;
        out_last_o  <= mux_last;
      end else if (free) begin
        out_valid_o <= 1'b0;
      end
      if (state == IDLE) begin
        if (acc) begin
          if (mux_last) begin
            ptr <= win_idx;
          end else begin
            state   <= LOCKED;
            owner   <= win_idx;
            grant_o <= win_oh;
          end
        end
      end else if (acc && mux_last) begin
        state   <= IDLE;
        ptr     <= owner;
        grant_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench: a spec-level model predicts accepts and pushes expected
// beats; a negedge monitor pops and compares on every output handshake.
module tb_onehot_rr_arbiter;
  localparam int Count = 3;
  localparam int Width = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [Count-1:0]            req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [Count-1:0][Width-1:0] req_data_i;
  logic                        out_valid_o, out_last_o, out_ready_i;
  logic [Width-1:0]            out_data_o;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.Count(Count), .Width(Width)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i)
  );

  int n_cmp = 0, n_bad = 0;
  logic [Width:0] sb[$];
  logic [Width:0] mon_exp;

  // stimulus-side beats and model state
  logic           cv[Count];
  logic [Width-1:0] cd[Count];
  logic           cl[Count];
  logic           rdy_in, rst_in;
  bit             m_locked, m_ov, m_known;
  int             m_owner, m_ptr, acc_k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    rst = rst_in;
    out_ready_i = rdy_in;
    for (int k = 0; k < Count; k++) begin
      req_valid_i[k] = cv[k];
      req_data_i[k]  = cd[k];
      req_last_i[k]  = cl[k];
    end
  endtask

  // One clock: check combinational outputs against the model, then advance.
  task automatic tick();
    bit free;
    int win, idx;
    logic [Count-1:0] er, eg;
    drive();
    #1;
    free = !m_ov || rdy_in;
    er = '0; eg = '0; win = -1;
    if (m_locked) begin
      eg[m_owner] = 1'b1;
      er[m_owner] = free;
    end else begin
      for (int i = 1; i <= Count; i++) begin
        idx = (m_ptr + i) % Count;
        if (cv[idx]) begin win = idx; break; end
      end
      if (win >= 0) er[win] = free;
    end
    if (rst_in) er = '0;
    chk("req_ready", req_ready_o, er);
    if (m_known) begin
      chk("grant", grant_o, eg);
      chk("out_valid", out_valid_o, m_ov);
    end
    acc_k = -1;
    for (int k = 0; k < Count; k++) if (cv[k] && er[k]) acc_k = k;
    @(posedge clk);
    if (rst_in) begin
      m_locked = 0; m_ptr = Count - 1; m_ov = 0; m_known = 1;
      sb.delete();
      acc_k = -1;
    end else if (acc_k >= 0) begin
      sb.push_back({cl[acc_k], cd[acc_k]});
      m_ov = 1;
      if (!m_locked) begin
        if (cl[acc_k]) m_ptr = acc_k;
        else begin m_locked = 1; m_owner = acc_k; end
      end else if (cl[acc_k]) begin
        m_locked = 0; m_ptr = m_owner;
      end
    end else if (free) begin
      m_ov = 0;
    end
    #1;
  endtask

  task automatic until_acc(input int k, input string nm);
    int n = 0;
    do begin tick(); n++; end while (acc_k != k && n < 40);
    if (acc_k != k) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no accept from req%0d within 40 cycles", nm, k);
    end
  endtask

  task automatic gen_rand();
    for (int k = 0; k < Count; k++) begin
      if (acc_k == k) cv[k] = 0;
      if (!cv[k] && $urandom_range(0, 2) != 0) begin
        cv[k] = 1;
        cd[k] = Width'($urandom);
        cl[k] = ($urandom_range(0, 2) == 0);
      end
    end
    rdy_in = ($urandom_range(0, 3) != 0);
    rst_in = ($urandom_range(0, 199) == 0);
  endtask

  always @(negedge clk) begin
    if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL out_beat: got %0h, expected no beat", {out_last_o, out_data_o});
      end else begin
        mon_exp = sb.pop_front();
        chk("out_beat", {out_last_o, out_data_o}, mon_exp);
      end
    end
  end

  initial begin
    logic [Width-1:0] held;
    m_locked = 0; m_ptr = Count - 1; m_ov = 0; m_known = 0; m_owner = 0;
    for (int k = 0; k < Count; k++) begin cv[k] = 1; cd[k] = Width'(8'h10 * (k + 1)); cl[k] = 1; end
    rdy_in = 1; rst_in = 1;

    // reset with all requesters valid
    tick(); tick();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_grant", grant_o, 0);
    rst_in = 0;
    drive(); #1;
    chk("rst_first_ready", req_ready_o, 3'b001);

    // single-beat rotation: 0x10,0x20,0x30,... leaves ptr at 0
    repeat (7) tick();
    for (int k = 0; k < Count; k++) cv[k] = 0;
    tick();

    // packet lock by req1 while req0/req2 wait
    cv[0] = 1; cd[0] = 8'h10; cl[0] = 1;
    cv[2] = 1; cd[2] = 8'h30; cl[2] = 1;
    cv[1] = 1; cd[1] = 8'hA1; cl[1] = 0;
    until_acc(1, "lock_a1");
    chk("lock_grant", grant_o, 3'b010);
    cd[1] = 8'hA2;
    until_acc(1, "lock_a2");
    chk("lock_grant2", grant_o, 3'b010);
    cd[1] = 8'hA3; cl[1] = 1;
    until_acc(1, "lock_a3");
    cv[1] = 0;
    drive(); #1;
    chk("lock_next_winner", req_ready_o, 3'b100);
    tick();

    // backpressure mid-packet from req0
    cv[2] = 0;
    until_acc(0, "bp_pre");
    cd[0] = 8'hB1; cl[0] = 0;
    until_acc(0, "bp_b1");
    cd[0] = 8'hB2;
    until_acc(0, "bp_b2");
    cd[0] = 8'hB3;
    held = 8'hB2;
    rdy_in = 0;
    repeat (4) begin
      drive(); #1;
      chk("bp_ready", req_ready_o, 0);
      tick();
      chk("bp_hold_data", out_data_o, held);
      chk("bp_hold_valid", out_valid_o, 1);
    end
    rdy_in = 1;
    until_acc(0, "bp_b3");
    cd[0] = 8'hB4; cl[0] = 1;
    until_acc(0, "bp_b4");

    // reset after the second of four beats from req2
    cv[0] = 0;
    cv[2] = 1; cd[2] = 8'hC1; cl[2] = 0;
    until_acc(2, "rm_c1");
    cd[2] = 8'hC2;
    until_acc(2, "rm_c2");
    cd[2] = 8'hC3;
    cv[0] = 1; cd[0] = 8'h55; cl[0] = 1;
    cv[1] = 1; cd[1] = 8'h66; cl[1] = 1;
    rst_in = 1;
    tick();
    rst_in = 0;
    chk("rm_grant", grant_o, 0);
    chk("rm_out_valid", out_valid_o, 0);
    drive(); #1;
    chk("rm_first_winner", req_ready_o, 3'b001);
    tick();

    // randomized traffic
    repeat (3000) begin
      gen_rand();
      tick();
    end

    // drain
    rst_in = 0; rdy_in = 1;
    for (int k = 0; k < Count; k++) cv[k] = 0;
    repeat (4) tick();
    chk("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Packet-level round-robin arbiter that shares one output stream between `Count` requesters. It produces a one-hot grant that selects the owning requester's word through an AND-OR one-hot mux, and drives a single registered output stage with a valid/ready handshake. Ownership is held from the first beat of a packet until its last beat is accepted. The block sits in front of any shared sink, such as a bus port or FIFO, that several producers feed.

## Interface

Parameters:

- `Count`, default 3: number of requesters; must be ≥ 1.
- `Width`, default 8: data word width; must be ≥ 1.

Ports:

- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: synchronous, active-high reset.
- `req_valid_i`, input, `[Count-1:0]`: per-requester beat valid.
- `req_data_i`, input, `[Width-1:0]` × `[Count]`: per-requester data word.
- `req_last_i`, input, `[Count-1:0]`: marks a beat as the last beat of its packet.
- `req_ready_o`, output, `[Count-1:0]`: per-requester accept; one-hot or zero.
- `grant_o`, output, `[Count-1:0]`: registered packet owner; one-hot or zero.
- `out_valid_o`, output, 1: output beat valid.
- `out_data_o`, output, `[Width-1:0]`: output beat data.
- `out_last_o`, output, 1: output beat is the last beat of its packet.
- `out_ready_i`, input, 1: downstream accept.

## Operation

- `free = !out_valid_o || out_ready_i`: the output register can take a new beat this cycle.
- A beat from requester k is accepted when `req_valid_i[k] && req_ready_o[k]`.
  - On accept: `out_data_o <= req_data_i[k]`, `out_last_o <= req_last_i[k]`, `out_valid_o <= 1`.
  - If `free` and no accept: `out_valid_o <= 0`. `out_data_o` and `out_last_o` hold.
- Data is selected by a one-hot AND-OR mux on the internal select. A zero select yields `'0`.
- Upstream rule: `req_valid_i`, `req_data_i` and `req_last_i` stay stable from assertion until the beat is accepted.

State machine (states `IDLE`, `LOCKED`):

- **IDLE**
  - `grant_o = 0`.
  - Winner is the first k with `req_valid_i[k]`, scanning `ptr+1, ptr+2, …` modulo `Count`.
  - If `free` and a winner exists: `req_ready_o` is one-hot on the winner, so the first beat is accepted in the same cycle.
  - Winner beat has `req_last_i` = 1: stay in `IDLE`, `ptr <= winner`.
  - Otherwise: go to `LOCKED`, `grant_o <= onehot(winner)`.
- **LOCKED**
  - `req_ready_o[owner] = free`; all other `req_ready_o` bits are 0.
  - Other requesters are ignored regardless of their valid.
  - Owner's last beat accepted: go to `IDLE`, `ptr <= owner`, `grant_o <= 0`.
- `ptr` holds the index of the last owner. Its reset value is `Count-1`, so requester 0 has first priority.
- `Count == 1`: requester 0 always wins.
- Invariants:
  - `grant_o` and `req_ready_o` are each zero or one-hot.
  - In `LOCKED`, `grant_o` is non-zero and `req_ready_o` is a subset of `grant_o`.

## Timing

- Reset values (applied on the clock edge with `rst_i` high):
  - `out_valid_o = 0`, `out_data_o = 0`, `out_last_o = 0`, `grant_o = 0`.
  - State `IDLE`, `ptr = Count-1`.
  - `req_ready_o` is forced to 0 while `rst_i` is high.
- `req_ready_o` is combinational from `req_valid_i`, state, `ptr`, `out_valid_o` and `out_ready_i`. There is no combinational path from any `req_data_i` to `req_ready_o`.
- Latency: a beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: one beat per cycle while `out_ready_i` = 1.
- Back-to-back packets: if the last beat is accepted in cycle N, a new winner can be accepted in cycle N+1 with no bubble.
- Stall: `out_valid_o` = 1 with `out_ready_i` = 0 holds all `out_*` stable and drives `req_ready_o` = 0.
- Simultaneous events: `out_ready_i` and a new accept in the same cycle replaces the output beat, with no drop and no duplicate.
- Reset mid-packet: the in-flight packet is abandoned and the output beat is discarded. The next cycle starts in `IDLE` with `ptr = Count-1`.
- A requester dropping `req_valid_i` while it owns the grant (`LOCKED`) keeps the lock until its last beat arrives; the stream stalls meanwhile.

## Test plan

Benches use `Count` = 3 and `Width` = 8 unless stated.

- **Reset:**
  - Stimulus: hold `rst_i` 2 cycles with all `req_valid_i` = 3'b111.
  - Required: `req_ready_o` = 0, `grant_o` = 0, `out_valid_o` = 0, `out_data_o` = 0.
  - First cycle after reset: `req_ready_o` = 3'b001.
- **Single-beat rotation:**
  - Stimulus: all three requesters continuously valid with `last` = 1 (data 0x10, 0x20, 0x30); `out_ready_i` = 1.
  - Required: outputs 0x10, 0x20, 0x30, 0x10, … on consecutive cycles; `grant_o` stays 0.
- **Packet lock:**
  - Stimulus: req1 sends 3 beats 0xA1, 0xA2, 0xA3 (`last` on the third) while req0 and req2 are valid.
  - Required: `grant_o` = 3'b010 from after the first accept until the cycle after 0xA3 is accepted.
  - Next winner is req2.
- **Backpressure:**
  - Stimulus: `out_ready_i` = 0 for 4 cycles mid-packet.
  - Required: `out_data_o` and `out_valid_o` hold; `req_ready_o` = 0.
  - On release, the next beat follows with one beat per cycle.
- **Reset mid-packet:**
  - Stimulus: assert `rst_i` after the second of four beats from req2.
  - Required: `grant_o` = 0 and `out_valid_o` = 0 next cycle; req0 wins first afterwards.
- **Formal:**
  - Required: `grant_o` and `req_ready_o` are one-hot or zero in every cycle, and `req_ready_o` is a subset of `grant_o` whenever the state is `LOCKED`.
